// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - frame-rate paddle/ball game controller for the 320x240 scene
module pong_game_ctrl #(
  parameter int SCR_W       = 320,
  parameter int SCR_H       = 240,
  parameter int PADDLE_W    = 32,
  parameter int PADDLE_Y    = 190,
  parameter int BALL_SZ     = 16,
  parameter int PADDLE_STEP = 8,
  parameter int BALL_STEP   = 2,
  parameter int LIVES_INIT  = 3,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_serve,
  output logic [8:0] paddle_x,
  output logic [8:0] ball_x,
  output logic [7:0] ball_y,
  output logic       ball_visible,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [1:0] state
);

  localparam int MW = $clog2(MISS_FRAMES);

  // All geometry is done in 10 bits so sums like ball_x + size + step never wrap.
  localparam logic [9:0] C_SCR_W    = 10'(SCR_W);
  localparam logic [9:0] C_SCR_H    = 10'(SCR_H);
  localparam logic [9:0] C_PAD_W    = 10'(PADDLE_W);
  localparam logic [9:0] C_PAD_Y    = 10'(PADDLE_Y);
  localparam logic [9:0] C_BALL     = 10'(BALL_SZ);
  localparam logic [9:0] C_PSTEP    = 10'(PADDLE_STEP);
  localparam logic [9:0] C_BSTEP    = 10'(BALL_STEP);
  localparam logic [9:0] C_PAD_MAX  = 10'(SCR_W - PADDLE_W);
  localparam logic [9:0] C_BALL_MAX = 10'(SCR_W - BALL_SZ);
  localparam logic [9:0] C_PAD_RST  = 10'((SCR_W - PADDLE_W) / 2);
  localparam logic [9:0] C_SEAT_OFF = 10'(PADDLE_W / 2 - BALL_SZ / 2);
  localparam logic [9:0] C_SEAT_Y   = 10'(PADDLE_Y - BALL_SZ);
  localparam logic [1:0] C_LIVES    = 2'(LIVES_INIT);
  localparam logic [MW-1:0] C_MISS_LAST = MW'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_MISS  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t          cur_state, nxt_state;
  logic [8:0]      paddle_q, paddle_d, bx_q, bx_d;
  logic [7:0]      by_q, by_d, score_q, score_d;
  logic            dx_q, dx_d, dy_q, dy_d;   // dx 1 = right, dy 1 = down
  logic [1:0]      lives_q, lives_d;
  logic            vis_q, vis_d, pend_q, pend_d;
  logic [MW-1:0]   miss_q, miss_d;

  logic [9:0] px, bx, by, pad_mv, bx_mv, seat_mv, seat_hold;
  logic       dx_mv, serve_now, crossing, overlap;

  assign px        = {1'b0, paddle_q};
  assign bx        = {1'b0, bx_q};
  assign by        = {2'b0, by_q};
  assign serve_now = pend_q | key_serve;
  assign seat_mv   = pad_mv + C_SEAT_OFF;
  assign seat_hold = px + C_SEAT_OFF;
  // Overlap is judged against where the paddle was before this frame's move.
  assign crossing  = dy_q && (by + C_BALL <= C_PAD_Y) && (by + C_BALL + C_BSTEP >= C_PAD_Y);
  assign overlap   = (bx + C_BALL > px) && (bx < px + C_PAD_W);

  // Candidate paddle position for this frame from the held keys, clamped to the scene.
  always_comb begin
    pad_mv = px;
    if (key_left && !key_right)
      pad_mv = (px <= C_PSTEP) ? '0 : px - C_PSTEP;
    else if (key_right && !key_left)
      pad_mv = (px + C_PAD_W + C_PSTEP >= C_SCR_W) ? C_PAD_MAX : px + C_PSTEP;
  end

  // Candidate horizontal ball step with reflection off the side walls.
  always_comb begin
    bx_mv = bx + C_BSTEP;
    dx_mv = dx_q;
    if (!dx_q) begin
      if (bx <= C_BSTEP) begin
        bx_mv = '0;
        dx_mv = 1'b1;
      end else begin
        bx_mv = bx - C_BSTEP;
      end
    end else if (bx + C_BALL + C_BSTEP >= C_SCR_W) begin
      bx_mv = C_BALL_MAX;
      dx_mv = 1'b0;
    end
  end

  // Next-state and per-frame game update; everything holds between frame ticks.
  always_comb begin
    nxt_state = cur_state;
    paddle_d  = paddle_q;
    bx_d      = bx_q;
    by_d      = by_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    lives_d   = lives_q;
    score_d   = score_q;
    vis_d     = vis_q;
    miss_d    = miss_q;
    pend_d    = frame_tick ? 1'b0 : (pend_q | key_serve);
    if (frame_tick) begin
      case (cur_state)
        S_SERVE: begin
          paddle_d = 9'(pad_mv);
          bx_d     = 9'(seat_mv);
          by_d     = 8'(C_SEAT_Y);
          if (serve_now) begin
            nxt_state = S_PLAY;
            dx_d      = 1'b1;
            dy_d      = 1'b0;
          end
        end
        S_PLAY: begin
          paddle_d = 9'(pad_mv);
          bx_d     = 9'(bx_mv);
          dx_d     = dx_mv;
          if (!dy_q) begin
            if (by <= C_BSTEP) begin
              by_d = '0;
              dy_d = 1'b1;
            end else begin
              by_d = 8'(by - C_BSTEP);
            end
          end else if (crossing && overlap) begin
            by_d    = 8'(C_SEAT_Y);
            dy_d    = 1'b0;
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          end else if (by + C_BALL + C_BSTEP >= C_SCR_H) begin
            lives_d = lives_q - 2'd1;
            vis_d   = 1'b0;
            if (lives_q == 2'd1) begin
              nxt_state = S_OVER;
            end else begin
              nxt_state = S_MISS;
              miss_d    = '0;
            end
          end else begin
            by_d = 8'(by + C_BSTEP);
          end
        end
        S_MISS: begin
          vis_d  = 1'b0;
          miss_d = miss_q + MW'(1);
          if (miss_q == C_MISS_LAST) begin
            nxt_state = S_SERVE;
            vis_d     = 1'b1;
            bx_d      = 9'(seat_hold);
            by_d      = 8'(C_SEAT_Y);
          end
        end
        S_OVER: begin
          vis_d   = 1'b0;
          lives_d = '0;
          if (serve_now) begin
            nxt_state = S_SERVE;
            lives_d   = C_LIVES;
            score_d   = '0;
            paddle_d  = 9'(C_PAD_RST);
            bx_d      = 9'(C_PAD_RST + C_SEAT_OFF);
            by_d      = 8'(C_SEAT_Y);
            vis_d     = 1'b1;
          end
        end
        default: nxt_state = S_SERVE;
      endcase
    end
  end

  // Game state register with synchronous reset to the serve position.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_SERVE;
      paddle_q  <= 9'(C_PAD_RST);
      bx_q      <= 9'(C_PAD_RST + C_SEAT_OFF);
      by_q      <= 8'(C_SEAT_Y);
      dx_q      <= 1'b1;
      dy_q      <= 1'b0;
      lives_q   <= C_LIVES;
      score_q   <= '0;
      vis_q     <= 1'b1;
      miss_q    <= '0;
      pend_q    <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      paddle_q  <= paddle_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      vis_q     <= vis_d;
      miss_q    <= miss_d;
      pend_q    <= pend_d;
    end
  end

  assign paddle_x     = paddle_q;
  assign ball_x       = bx_q;
  assign ball_y       = by_q;
  assign ball_visible = vis_q;
  assign lives        = lives_q;
  assign score        = score_q;
  assign state        = cur_state;

endmodule
